// File: rtl/cw305_mailbox_if.sv
// rtl/cw305_mailbox_if.sv - core-side RX/TX stream bundle of the CW305 mailbox
interface cw305_mailbox_if;
    logic [31:0] rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic [31:0] tx_data_i;
    logic        tx_valid_i;
    logic        tx_ready_o;

    modport master (
        output rx_data_o, rx_valid_o, tx_ready_o,
        input  rx_ready_i, tx_data_i, tx_valid_i
    );

    modport slave (
        input  rx_data_o, rx_valid_o, tx_ready_o,
        output rx_ready_i, tx_data_i, tx_valid_i
    );
endinterface

// File: rtl/cw305_mailbox_ctrl.sv
// rtl/cw305_mailbox_ctrl.sv - host<->core mailbox: RX FIFO, TX handshake FSM, status word
// Optional TX acknowledge timeout enabled by defining MAILBOX_TIMEOUT_EN.
module cw305_mailbox_ctrl #(
    parameter int pDEPTH   = 4,
    parameter int pCNT_W   = 3,
    parameter int pTIMEOUT = 65535
) (
    input  logic                crypto_clk,
    input  logic                reset_i,
    input  logic [31:0]         usb_word_i,
    input  logic                usb_word_stb_i,
    input  logic [31:0]         ext_flags_i,
    cw305_mailbox_if.master     core,
    output logic [31:0]         pulpino_to_usb_o,
    output logic [31:0]         status_flags_o
);
    localparam int PTR_W = pCNT_W - 1;
    localparam logic [pCNT_W-1:0] FULL_CNT = pCNT_W'(pDEPTH);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    logic [31:0]       mem [pDEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [pCNT_W-1:0] count;
    logic              stb_q, ack_q, clr_q;
    logic              ovf_sticky, tmo_sticky;
    logic [0:0]        state;
    logic [31:0]       status_next;

    logic full, push, pop, push_ok, ovf_set, ack_edge, clr_edge, tmo_fire;

    assign full     = (count == FULL_CNT);
    assign push     = usb_word_stb_i & ~stb_q;
    assign pop      = core.rx_valid_o & core.rx_ready_i;
    assign push_ok  = push & (~full | pop);
    assign ovf_set  = push & full & ~pop;
    assign ack_edge = ext_flags_i[0] & ~ack_q;
    assign clr_edge = ext_flags_i[1] & ~clr_q;

    assign core.rx_valid_o = (count != '0);
    assign core.rx_data_o  = mem[rd_ptr];
    assign core.tx_ready_o = (state == ST_IDLE) & ~reset_i;

    always_ff @(posedge crypto_clk) begin
        if (push_ok)
            mem[wr_ptr] <= usb_word_i;
    end

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            stb_q      <= 1'b1;
            ack_q      <= 1'b1;
            clr_q      <= 1'b1;
            ovf_sticky <= 1'b0;
        end else begin
            stb_q <= usb_word_stb_i;
            ack_q <= ext_flags_i[0];
            clr_q <= ext_flags_i[1];
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // a new overflow in the clearing cycle must not be lost
            if (ovf_set)
                ovf_sticky <= 1'b1;
            else if (clr_edge)
                ovf_sticky <= 1'b0;
        end
    end

`ifdef MAILBOX_TIMEOUT_EN
    localparam int TMO_W = (pTIMEOUT > 1) ? $clog2(pTIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(pTIMEOUT - 1);
    logic [TMO_W-1:0] tmo_cnt;

    // an ack in the same cycle takes precedence over the timeout
    assign tmo_fire = (state == ST_PEND) & ~ack_edge & (tmo_cnt == TMO_LAST);

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            tmo_cnt    <= '0;
            tmo_sticky <= 1'b0;
        end else begin
            if (state == ST_PEND && !ack_edge && !tmo_fire)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;
            if (tmo_fire)
                tmo_sticky <= 1'b1;
            else if (clr_edge)
                tmo_sticky <= 1'b0;
        end
    end
`else
    assign tmo_fire   = 1'b0;
    assign tmo_sticky = 1'b0;
`endif

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            state            <= ST_IDLE;
            pulpino_to_usb_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (core.tx_valid_i) begin
                        pulpino_to_usb_o <= core.tx_data_i;
                        state            <= ST_PEND;
                    end
                end
                default: begin
                    if (ack_edge || tmo_fire)
                        state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        status_next              = '0;
        status_next[0]           = (state == ST_PEND);
        status_next[1]           = full;
        status_next[2]           = ovf_sticky;
        status_next[3]           = tmo_sticky;
        status_next[4 +: pCNT_W] = count;
    end

    always_ff @(posedge crypto_clk) begin
        if (reset_i)
            status_flags_o <= '0;
        else
            status_flags_o <= status_next;
    end
endmodule

// File: tb/tb_cw305_mailbox_ctrl.sv
// tb/tb_cw305_mailbox_ctrl.sv - directed self-checking bench for cw305_mailbox_ctrl
module tb_cw305_mailbox_ctrl;
    logic        crypto_clk = 1'b0;
    logic        reset_i;
    logic [31:0] usb_word_i;
    logic        usb_word_stb_i;
    logic [31:0] ext_flags_i;
    logic [31:0] pulpino_to_usb_o;
    logic [31:0] status_flags_o;
    int          n_cmp = 0;
    int          n_err = 0;

    cw305_mailbox_if mbx ();

    cw305_mailbox_ctrl #(.pDEPTH(4), .pCNT_W(3), .pTIMEOUT(16)) dut (
        .crypto_clk       (crypto_clk),
        .reset_i          (reset_i),
        .usb_word_i       (usb_word_i),
        .usb_word_stb_i   (usb_word_stb_i),
        .ext_flags_i      (ext_flags_i),
        .core             (mbx.master),
        .pulpino_to_usb_o (pulpino_to_usb_o),
        .status_flags_o   (status_flags_o)
    );

    always #5 crypto_clk = ~crypto_clk;

    task automatic tick();
        @(posedge crypto_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [31:0] w);
        usb_word_i     = w;
        usb_word_stb_i = 1'b1;
        tick();
        usb_word_stb_i = 1'b0;
        tick();
    endtask

    initial begin
        reset_i        = 1'b1;
        usb_word_i     = '0;
        usb_word_stb_i = 1'b1;
        ext_flags_i    = '0;
        mbx.rx_ready_i = 1'b0;
        mbx.tx_data_i  = '0;
        mbx.tx_valid_i = 1'b0;
        repeat (3) tick();
        chk("rst_rx_valid", {31'd0, mbx.rx_valid_o}, 32'd0);
        chk("rst_tx_ready", {31'd0, mbx.tx_ready_o}, 32'd0);
        chk("rst_status", status_flags_o, 32'd0);
        chk("rst_pulpino", pulpino_to_usb_o, 32'd0);

        // strobe held across reset release must not push
        reset_i = 1'b0;
        tick();
        tick();
        chk("no_push_after_rst", {31'd0, mbx.rx_valid_o}, 32'd0);
        usb_word_stb_i = 1'b0;
        tick();

        // level strobe held 3 cycles -> one entry
        usb_word_i     = 32'hDEADBEEF;
        usb_word_stb_i = 1'b1;
        tick();
        chk("push_latency_valid", {31'd0, mbx.rx_valid_o}, 32'd1);
        chk("push_latency_data", mbx.rx_data_o, 32'hDEADBEEF);
        tick();
        tick();
        usb_word_stb_i = 1'b0;
        tick();
        chk("level_stb_status", status_flags_o, 32'h0000_0010);
        mbx.rx_ready_i = 1'b1;
        tick();
        mbx.rx_ready_i = 1'b0;
        chk("pop_empty", {31'd0, mbx.rx_valid_o}, 32'd0);

        // overflow: 5 pushes into depth 4
        for (int i = 1; i <= 5; i++)
            strobe(32'(i));
        chk("ovf_status", status_flags_o, 32'h0000_0046);
        mbx.rx_ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain_%0d", i), mbx.rx_data_o, 32'(i));
            tick();
        end
        mbx.rx_ready_i = 1'b0;
        chk("drained_valid", {31'd0, mbx.rx_valid_o}, 32'd0);

        ext_flags_i[1] = 1'b1;
        tick();
        ext_flags_i[1] = 1'b0;
        tick();
        chk("clr_sticky", status_flags_o, 32'd0);

        // push and pop together while full
        for (int i = 1; i <= 4; i++)
            strobe(32'(i));
        usb_word_i     = 32'h5;
        usb_word_stb_i = 1'b1;
        mbx.rx_ready_i = 1'b1;
        tick();
        usb_word_stb_i = 1'b0;
        mbx.rx_ready_i = 1'b0;
        tick();
        chk("pushpop_head", mbx.rx_data_o, 32'h2);
        chk("pushpop_status", status_flags_o, 32'h0000_0042);
        mbx.rx_ready_i = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("pushpop_drain_%0d", i), mbx.rx_data_o, 32'(i));
            tick();
        end
        mbx.rx_ready_i = 1'b0;

        // TX handshake with ack
        chk("tx_idle_ready", {31'd0, mbx.tx_ready_o}, 32'd1);
        mbx.tx_data_i  = 32'hCAFE0001;
        mbx.tx_valid_i = 1'b1;
        tick();
        mbx.tx_valid_i = 1'b0;
        mbx.tx_data_i  = 32'h1234_5678;
        chk("tx_word", pulpino_to_usb_o, 32'hCAFE0001);
        chk("tx_pend_ready", {31'd0, mbx.tx_ready_o}, 32'd0);
        tick();
        chk("tx_pend_status", status_flags_o, 32'h1);
        chk("tx_hold", pulpino_to_usb_o, 32'hCAFE0001);
        ext_flags_i[0] = 1'b1;
        tick();
        chk("ack_ready", {31'd0, mbx.tx_ready_o}, 32'd1);
        tick();
        chk("ack_status", status_flags_o, 32'd0);
        chk("ack_keep_word", pulpino_to_usb_o, 32'hCAFE0001);
        ext_flags_i[0] = 1'b0;
        tick();

        // un-acked TX
        mbx.tx_data_i  = 32'hCAFE0002;
        mbx.tx_valid_i = 1'b1;
        tick();
        mbx.tx_valid_i = 1'b0;
`ifdef MAILBOX_TIMEOUT_EN
        repeat (15) tick();
        chk("tmo_still_pend", {31'd0, mbx.tx_ready_o}, 32'd0);
        tick();
        chk("tmo_idle", {31'd0, mbx.tx_ready_o}, 32'd1);
        tick();
        chk("tmo_status", status_flags_o, 32'h8);
        ext_flags_i[1] = 1'b1;
        tick();
        ext_flags_i[1] = 1'b0;
        tick();
        chk("tmo_clear", status_flags_o, 32'd0);
`else
        repeat (40) tick();
        chk("no_tmo_pend", {31'd0, mbx.tx_ready_o}, 32'd0);
        chk("no_tmo_status", status_flags_o, 32'h1);
        ext_flags_i[0] = 1'b1;
        tick();
        ext_flags_i[0] = 1'b0;
        tick();
        chk("no_tmo_ack", status_flags_o, 32'd0);
`endif

        // reset mid-transfer
        strobe(32'hA);
        strobe(32'hB);
        mbx.tx_data_i  = 32'hCAFE0003;
        mbx.tx_valid_i = 1'b1;
        tick();
        mbx.tx_valid_i = 1'b0;
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        tick();
        chk("midrst_status", status_flags_o, 32'd0);
        chk("midrst_rx_valid", {31'd0, mbx.rx_valid_o}, 32'd0);
        chk("midrst_pulpino", pulpino_to_usb_o, 32'd0);
        strobe(32'hC);
        chk("post_rst_push", mbx.rx_data_o, 32'hC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
